// File: rtl/pwm_motor_pkg.sv
// Shared types and constants for the H-bridge PWM driver.
// No logic here; imported by pwm_motor and its testbench.
package pwm_motor_pkg;
  typedef enum logic {RUN = 1'b0, DEAD = 1'b1} state_t;

  localparam logic [1:0] SPD_OFF  = 2'b00;
  localparam logic [1:0] SPD_25   = 2'b01;
  localparam logic [1:0] SPD_50   = 2'b10;
  localparam logic [1:0] SPD_FULL = 2'b11;

  localparam int EN_BIT  = 0;
  localparam int IN1_BIT = 1;
  localparam int IN2_BIT = 2;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer per bit; 2-cycle latency, no flow control.
// Reset clears both stages.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pwm_motor.sv
// Single-channel H-bridge driver: synchronized switches -> PWM enable + direction pins.
// Outputs registered one cycle after the compare; settings change only at period boundaries.
module pwm_motor
  import pwm_motor_pkg::*;
#(
  parameter int PERIOD      = 8,
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] switch,
  output logic [2:0] motor
);
  localparam int DW  = $clog2(PERIOD + 1);
  localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(PERIOD - 1);

  logic [2:0]     sw_s;
  logic [DW-1:0]  cnt;
  logic [DW-1:0]  duty;
  logic [DW-1:0]  new_duty;
  logic [DCW-1:0] dcnt;
  logic           dir;
  logic           boundary;
  state_t         state;

  sync2 #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (switch),
    .q     (sw_s)
  );

  function automatic logic [DW-1:0] duty_of(input logic [1:0] code);
    case (code)
      SPD_OFF: duty_of = '0;
      SPD_25:  duty_of = DW'(PERIOD / 4);
      SPD_50:  duty_of = DW'(PERIOD / 2);
      default: duty_of = DW'(PERIOD);
    endcase
  endfunction

  // Zero duty coasts with both direction pins low; IN1/IN2 can never both be high.
  function automatic logic [2:0] drive(input logic [DW-1:0] c, input logic [DW-1:0] d,
                                       input logic r);
    logic [2:0] m;
    m          = '0;
    m[EN_BIT]  = (c < d);
    m[IN1_BIT] = (d != '0) && !r;
    m[IN2_BIT] = (d != '0) && r;
    return m;
  endfunction

  always_comb begin
    new_duty = duty_of(sw_s[1:0]);
    boundary = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      duty  <= '0;
      dir   <= 1'b0;
      dcnt  <= '0;
      state <= RUN;
      motor <= '0;
    end else begin
      case (state)
        RUN: begin
          motor <= drive(cnt, duty, dir);
          if (boundary) begin
            cnt <= '0;
            if (sw_s[2] == dir || (duty == '0 && new_duty == '0)) begin
              duty <= new_duty;
              dir  <= sw_s[2];
            end else begin
              state <= DEAD;
              motor <= '0;
              dcnt  <= DCW'(DEAD_CYCLES - 1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEAD: begin
          if (dcnt == '0) begin
            // The exit cycle doubles as the cnt=0 compare, so exactly DEAD_CYCLES
            // output cycles are low and the new period starts with no extra gap.
            state <= RUN;
            dir   <= sw_s[2];
            duty  <= new_duty;
            motor <= drive('0, new_duty, sw_s[2]);
            cnt   <= DW'(1);
          end else begin
            dcnt  <= dcnt - 1'b1;
            motor <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_motor.sv
// Directed test of pwm_motor with defaults (PERIOD=8, DEAD_CYCLES=4), clk 20 ns.
// Expected motor values are hand-derived from the edge index after reset release.
module tb_pwm_motor;
  logic       clk;
  logic       rst_n;
  logic [2:0] switch;
  logic [2:0] motor;

  int vectors     = 0;
  int miscompares = 0;
  int a           = 0;

  localparam logic [2:0] OFF = 3'b000;

  pwm_motor u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .switch (switch),
    .motor  (motor)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    a++;
  endtask

  task automatic check(input string tag, input logic [2:0] exp);
    vectors++;
    assert (motor === exp)
    else begin
      miscompares++;
      $error("FAIL %s edge=%0d: motor=%b expected %b", tag, a, motor, exp);
    end
  endtask

  // 25% duty: EN high on compare phases 0 and 1 of each period.
  function automatic logic [2:0] pat(input int ph, input logic rev);
    logic [2:0] m;
    m = rev ? 3'b100 : 3'b010;
    if (ph < 2) m[0] = 1'b1;
    return m;
  endfunction

  initial begin
    rst_n  = 1'b0;
    switch = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", OFF);
    end
    rst_n = 1'b1;
    a = 0;

    // 1: idle, speed 00
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", OFF);
    end

    // 2: forward 25%, latched at boundary edge 24
    switch = 3'b001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("fwd25", (a <= 24) ? OFF : pat((a - 1) % 8, 1'b0));
    end

    // 3: reverse 25% with dead time at boundary edge 48
    switch = 3'b101;
    for (int i = 0; i < 28; i++) begin
      tick();
      if (a <= 47)      check("rev_pre",  pat((a - 1) % 8, 1'b0));
      else if (a <= 51) check("rev_dead", OFF);
      else              check("rev25",    pat((a - 52) % 8, 1'b1));
    end

    // 4: forward full, reversal from rev 25% at boundary edge 75
    switch = 3'b011;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (a <= 74)      check("full_pre",  pat((a - 52) % 8, 1'b1));
      else if (a <= 78) check("full_dead", OFF);
      else              check("fwdfull",   3'b011);
    end

    // 5: reverse full, dead time at boundary edge 94
    switch = 3'b111;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (a <= 93)      check("rfull_pre",  3'b011);
      else if (a <= 97) check("rfull_dead", OFF);
      else              check("revfull",    3'b101);
    end

    // 6: asynchronous reset mid-period, no clock edge before the check
    #3 rst_n = 1'b0;
    switch = 3'b001;
    #1 check("async_rst", OFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_hold", OFF);
    end
    rst_n = 1'b1;
    a = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      check("restart", (a <= 8) ? OFF : pat((a - 1) % 8, 1'b0));
    end

    // 7: back to coast, then direction flip at speed 00 takes no dead time
    switch = 3'b000;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("coast", (a <= 32) ? pat((a - 1) % 8, 1'b0) : OFF);
    end
    switch = 3'b100;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("coast_flip", OFF);
    end
    switch = 3'b101;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("rev_nodead", (a <= 64) ? OFF : pat((a - 1) % 8, 1'b1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
